pipe_skid32: RTL and testbench

Two-entry skid-buffered pipeline latch that sits directly upstream of a stage's dffe32 bank and supplies its 32-bit payload. It accepts one word per cycle from the producing stage under a valid/ready handshake. It presents the word to the consuming stage one cycle later and absorbs one extra word when the consumer stalls. Its ready output is fully registered, so no combinational path runs from the consumer's stall back to the producer.

---
 rtl/pipe_skid32_if.sv | 23 ++
 rtl/pipe_skid32.sv | 88 ++++++++
 tb/tb_pipe_skid32.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pipe_skid32_if.sv
// Valid/ready handshake bundle for pipe_skid32: producer side (in_*) and consumer side (out_*).
interface pipe_skid32_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  // The skid block itself: sinks the producer stream, sources the consumer stream.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // Environment side: drives the producer stream and the consumer's ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid32.sv
// Two-entry skid-buffered pipeline latch with a registered in_ready; supplies a stage's payload.
module pipe_skid32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               r,
  input  logic               flush,
  pipe_skid32_if.slave       bus
);

  // Encoding is {main_v, skid_v}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             main_v, skid_v;
  logic             accept, take;
  logic             main_en, main_from_skid, skid_en;

  assign main_v = state_q[1];
  assign skid_v = state_q[0];

  assign bus.out_valid = main_v;
  assign bus.out_data  = main_q;
  assign bus.in_ready  = ~skid_v;

  assign accept = bus.in_valid & ~skid_v;
  assign take   = main_v & bus.out_ready;

  always_ff @(posedge clk or negedge r) begin
    if (!r) state_q <= EMPTY;
    else    state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_en = 1'b1;
          state_d = HALF;
        end
      end
      HALF: begin
        if (accept && take) begin
          main_en = 1'b1;
        end else if (accept) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (take) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides everything: no loads, both entries invalidated.
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_en) main_q <= main_from_skid ? skid_q : bus.in_data;
      if (skid_en) skid_q <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_pipe_skid32.sv
// Self-checking bench for pipe_skid32: directed vector table, async-reset sequence, random scoreboard run.
module tb_pipe_skid32;

  logic clk = 1'b0;
  logic r;
  logic flush;

  pipe_skid32_if #(.WIDTH(32)) bus();

  pipe_skid32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .r     (r),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        eov;
    logic        eir;
    logic [31:0] eod;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          tests = 0;
  int          failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic fl, input logic iv, input logic [31:0] d, input logic ordy,
                     input logic eov, input logic eir, input logic [31:0] eod);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eov = eov; v.eir = eir; v.eod = eod;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    flush         = fl;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  initial begin
    // Streaming 1..8 with the consumer always ready.
    for (int unsigned i = 1; i <= 8; i++) add(0, 1, i, 1, 1, 1, i);
    add(0, 0, 0, 1, 0, 1, 0);
    // Stall/skid: 0x22222222 lands in skid, 0x33333333 held upstream.
    add(0, 1, 32'h1111_1111, 1, 1, 1, 32'h1111_1111);
    add(0, 1, 32'h2222_2222, 0, 1, 0, 32'h1111_1111);
    for (int unsigned i = 0; i < 10; i++) add(0, 1, 32'h3333_3333, 0, 1, 0, 32'h1111_1111);
    add(0, 1, 32'h3333_3333, 1, 1, 1, 32'h2222_2222);
    add(0, 1, 32'h3333_3333, 1, 1, 1, 32'h3333_3333);
    add(0, 0, 0, 1, 0, 1, 0);
    // Flush from FULL with a take and an offered word on the same edge.
    add(0, 1, 32'h0000_0055, 0, 1, 1, 32'h0000_0055);
    add(0, 1, 32'h0000_0066, 0, 1, 0, 32'h0000_0055);
    add(1, 1, 32'hDEAD_BEEF, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0, 1, 0);
    add(0, 1, 32'h0000_0042, 0, 1, 1, 32'h0000_0042);
    add(0, 0, 0, 1, 0, 1, 0);

    r = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("reset out_data",  bus.out_data,           32'd0);
    @(negedge clk);
    r = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].eov});
      check($sformatf("vec%0d in_ready", i),  {31'd0, bus.in_ready},  {31'd0, vecs[i].eir});
      if (vecs[i].eov) check($sformatf("vec%0d out_data", i), bus.out_data, vecs[i].eod);
      if (bus.out_valid === 1'b1 && bus.out_data === 32'hDEAD_BEEF) check("deadbeef leaked", bus.out_data, 32'd0);
      @(negedge clk);
    end

    // Asynchronous reset in FULL, asserted mid-cycle.
    drive(0, 1, 32'hAAAA_0001, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1, 32'hAAAA_0002, 0);
    @(posedge clk);
    #1;
    check("full before reset in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("full before reset out_data", bus.out_data, 32'hAAAA_0001);
    #2;
    r = 1'b0;
    #1;
    check("async reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async reset in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("async reset out_data",  bus.out_data,           32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    r = 1'b1;

    // Random traffic against a scoreboard; occupancy model predicts in_ready/out_valid.
    for (int unsigned cyc = 0; cyc < 400; cyc++) begin
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom, ($urandom_range(0, 3) != 0));
      #1;
      check("rnd out_valid", {31'd0, bus.out_valid}, {31'd0, (sb.size() > 0)});
      check("rnd in_ready",  {31'd0, bus.in_ready},  {31'd0, (sb.size() < 2)});
      if (sb.size() > 0 && bus.out_valid === 1'b1) check("rnd out_data", bus.out_data, sb[0]);
      if (bus.out_valid === 1'b1 && bus.out_ready && sb.size() > 0) void'(sb.pop_front());
      if (bus.in_valid && bus.in_ready === 1'b1) sb.push_back(bus.in_data);
      if (flush) sb.delete();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
